// File: rtl/pet_stats.sv
`timescale 1ns/1ps
// pet_stats: six-channel pet-status engine.
//
// A free-running divider produces a one-cycle `tick` every TICK_DIV clocks.
// Each tick ages the need selected by random[2:0] (0..5; 6/7 select nothing).
// Edge-detected care buttons relieve their need. A mode FSM (AWAKE / ASLEEP /
// DEAD) gates care and decay; a death counter moves the pet to DEAD after
// DEATH_TICKS consecutive ticks with health at MAX.
//
// Build option: define PET_STATS_SLEEP_EN to build the ASLEEP state with
// energy recovery and auto-wake. Without it, button [4] is a plain care
// press on energy and `asleep` is tied low.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   inputs     buttons: [0] feed [1] play [2] medicine [3] clean
//              [4] sleep [5] socialize [7:6] unused
//   random     LFSR value, only [2:0] used
//   hunger, happiness, health, hygiene, energy, social
//              need levels, 0 = satisfied, MAX = critical
//   asleep     high in ASLEEP
//   dead       high in DEAD
//   alert      registered: any stat at MAX
//   tick       one-cycle pulse per tick period
module pet_stats #(
  parameter int STAT_W      = 4,
  parameter int TICK_DIV    = 1000,
  parameter int DECAY_STEP  = 1,
  parameter int CARE_STEP   = 1,
  parameter int DEATH_TICKS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        inputs,
  input  logic [7:0]        random,
  output logic [STAT_W-1:0] hunger,
  output logic [STAT_W-1:0] happiness,
  output logic [STAT_W-1:0] health,
  output logic [STAT_W-1:0] hygiene,
  output logic [STAT_W-1:0] energy,
  output logic [STAT_W-1:0] social,
  output logic              asleep,
  output logic              dead,
  output logic              alert,
  output logic              tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEATH_TICKS > 0) ? $clog2(DEATH_TICKS + 1) : 1;

  localparam logic [CW-1:0]       TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0]       DEATH_LAST = DW'(DEATH_TICKS);
  localparam logic [STAT_W-1:0]   MAX        = '1;
  localparam logic [STAT_W+1:0]   MAX_X      = {2'b00, MAX};
  localparam logic [STAT_W+1:0]   UP_X       = (STAT_W + 2)'(DECAY_STEP);
  localparam logic [STAT_W+1:0]   DN_X       = (STAT_W + 2)'(CARE_STEP);

  localparam int HEALTH_IDX = 2;
  localparam int ENERGY_IDX = 4;

`ifdef PET_STATS_SLEEP_EN
  // Button [4] is the sleep toggle, not a care button for energy.
  localparam logic [5:0] CARE_MASK = 6'b101111;
  typedef enum logic [1:0] {AWAKE, ASLEEP, DEAD} mode_t;
`else
  localparam logic [5:0] CARE_MASK = 6'b111111;
  typedef enum logic [0:0] {AWAKE, DEAD} mode_t;
`endif

  mode_t             state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              tick_q;
  logic [5:0]        inputs_q;
  logic              armed_q;
  logic [5:0]        press_q;
  logic              alert_q;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [STAT_W-1:0] stat_q [6];
  logic [STAT_W-1:0] stat_d [6];
  logic [STAT_W+1:0] up     [6];
  logic [STAT_W+1:0] dn     [6];
  logic [2:0]        sel;
  logic              any_max;
  logic              unused_bits;

  assign unused_bits = ^{inputs[7:6], random[7:3]};

  // Saturating net step, evaluated two bits wider than the stat so that
  // both the underflow and the overflow side are visible.
  function automatic logic [STAT_W-1:0] sat_step(input logic [STAT_W-1:0] x,
                                                 input logic [STAT_W+1:0] u,
                                                 input logic [STAT_W+1:0] d);
    logic [STAT_W+1:0] s;
    s = {2'b00, x} + u;
    if (s < d) begin
      return '0;
    end
    s = s - d;
    if (s > MAX_X) begin
      return MAX;
    end
    return s[STAT_W-1:0];
  endfunction

  always_comb begin
    any_max = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (stat_q[i] == MAX) any_max = 1'b1;
    end
  end

  // Divider, button edge detect and alert register.
  // armed_q suppresses a press on the first clock after reset, so a button
  // still held when reset releases is not seen as a new press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      inputs_q <= '0;
      armed_q  <= 1'b0;
      press_q  <= '0;
      alert_q  <= 1'b0;
    end else begin
      cnt_q    <= (cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1;
      tick_q   <= (cnt_q == TICK_LAST);
      inputs_q <= inputs[5:0];
      armed_q  <= 1'b1;
      press_q  <= armed_q ? (inputs[5:0] & ~inputs_q) : '0;
      alert_q  <= any_max;
    end
  end

  // Mode FSM: next state, per-stat up/down steps and death counter.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    sel     = random[2:0];
    for (int unsigned i = 0; i < 6; i++) begin
      up[i] = '0;
      dn[i] = '0;
    end

    case (state_q)
      AWAKE: begin
        for (int unsigned i = 0; i < 6; i++) begin
          if (tick_q && (sel == 3'(i))) up[i] = UP_X;
          if (press_q[i] && CARE_MASK[i]) dn[i] = DN_X;
        end
`ifdef PET_STATS_SLEEP_EN
        if (press_q[ENERGY_IDX]) state_d = ASLEEP;
`endif
      end
`ifdef PET_STATS_SLEEP_EN
      ASLEEP: begin
        if (tick_q) begin
          if (sel == 3'd0) up[0] = UP_X;
          dn[ENERGY_IDX] = DN_X;
        end
        if (press_q[ENERGY_IDX]) state_d = AWAKE;
      end
`endif
      default: begin
        // DEAD: no steps, stats hold
      end
    endcase

    for (int unsigned i = 0; i < 6; i++) begin
      stat_d[i] = sat_step(stat_q[i], up[i], dn[i]);
    end

`ifdef PET_STATS_SLEEP_EN
    if ((state_q == ASLEEP) && tick_q && (stat_d[ENERGY_IDX] == '0)) begin
      state_d = AWAKE;
    end
`endif

    // Death check uses health before this tick's update and overrides
    // any other transition.
    if (tick_q && (state_q != DEAD)) begin
      dcnt_d = (stat_q[HEALTH_IDX] == MAX) ? dcnt_q + 1'b1 : '0;
      if (dcnt_d == DEATH_LAST) state_d = DEAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= AWAKE;
      dcnt_q  <= '0;
      for (int unsigned i = 0; i < 6; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      for (int unsigned i = 0; i < 6; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  assign hunger    = stat_q[0];
  assign happiness = stat_q[1];
  assign health    = stat_q[2];
  assign hygiene   = stat_q[3];
  assign energy    = stat_q[4];
  assign social    = stat_q[5];
`ifdef PET_STATS_SLEEP_EN
  assign asleep    = (state_q == ASLEEP);
`else
  assign asleep    = 1'b0;
`endif
  assign dead      = (state_q == DEAD);
  assign alert     = alert_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_pet_stats.sv
`timescale 1ns/1ps
module tb_pet_stats;

  localparam int STAT_W = 4;
  localparam int TDIV   = 4;
  localparam int DECAY  = 1;
  localparam int CARE   = 1;
  localparam int DEATH  = 2;
  localparam int MAXV   = 15;

`ifdef PET_STATS_SLEEP_EN
  localparam bit SLEEP_EN = 1'b1;
`else
  localparam bit SLEEP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] inputs;
  logic [7:0] random;
  logic [3:0] hunger, happiness, health, hygiene, energy, social;
  logic       asleep, dead, alert, tick;

  pet_stats #(
    .STAT_W(STAT_W), .TICK_DIV(TDIV), .DECAY_STEP(DECAY),
    .CARE_STEP(CARE), .DEATH_TICKS(DEATH)
  ) dut (
    .clk(clk), .reset(reset), .inputs(inputs), .random(random),
    .hunger(hunger), .happiness(happiness), .health(health),
    .hygiene(hygiene), .energy(energy), .social(social),
    .asleep(asleep), .dead(dead), .alert(alert), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][3:0] st;
    logic asleep;
    logic dead;
    logic alert;
    logic tick;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // ---------------- reference model (behavioural, per clock edge) --------
  int       m_st[6];
  int       m_mode;     // 0 awake, 1 asleep, 2 dead
  int       m_dcnt;
  int       m_cnt;
  bit       m_tick;
  bit       m_alert;
  bit       m_armed;
  bit [7:0] m_prev;
  bit [7:0] m_press;
  int       m_ticks = 0;

  function automatic int clampv(input int v);
    if (v < 0) return 0;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_st[i] = 0;
    m_mode = 0; m_dcnt = 0; m_cnt = 0; m_tick = 0; m_alert = 0;
    m_armed = 0; m_prev = '0; m_press = '0;
  endtask

  task automatic model_edge(input bit [7:0] in_v, input bit [7:0] rnd_v);
    int nst[6];
    int nmode;
    bit nalert;
    int sel;
    int d;
    nalert = 0;
    for (int i = 0; i < 6; i++) if (m_st[i] == MAXV) nalert = 1;
    nst   = m_st;
    nmode = m_mode;
    sel   = int'(rnd_v[2:0]);
    if (m_tick) m_ticks++;
    if (m_mode != 2) begin
      for (int i = 0; i < 6; i++) begin
        d = 0;
        if (m_mode == 0) begin
          if (m_tick && sel == i) d += DECAY;
          if (m_press[i] && !(SLEEP_EN && i == 4)) d -= CARE;
        end else begin
          if (m_tick && i == 0 && sel == 0) d += DECAY;
          if (m_tick && i == 4) d -= CARE;
        end
        nst[i] = clampv(m_st[i] + d);
      end
      if (SLEEP_EN) begin
        if (m_press[4]) nmode = (m_mode == 0) ? 1 : 0;
        if (m_mode == 1 && m_tick && nst[4] == 0) nmode = 0;
      end
      if (m_tick) begin
        m_dcnt = (m_st[2] == MAXV) ? m_dcnt + 1 : 0;
        if (m_dcnt >= DEATH) nmode = 2;
      end
    end
    m_press = m_armed ? (in_v & ~m_prev) : 8'h00;
    m_prev  = in_v;
    m_armed = 1;
    m_tick  = (m_cnt == TDIV - 1);
    m_cnt   = (m_cnt + 1) % TDIV;
    m_st    = nst;
    m_mode  = nmode;
    m_alert = nalert;
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < 6; i++) e.st[i] = 4'(m_st[i]);
    e.asleep = (m_mode == 1);
    e.dead   = (m_mode == 2);
    e.alert  = m_alert;
    e.tick   = m_tick;
    q.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ---------------------------------
  string fname [6] = '{"hunger", "happiness", "health", "hygiene", "energy", "social"};

  always @(negedge clk) begin : monitor
    exp_t            e;
    logic [5:0][3:0] a;
    bit              bad;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {social, energy, hygiene, health, happiness, hunger};
      bad = 0;
      n_cmp++;
      for (int i = 0; i < 6; i++) begin
        if (a[i] !== e.st[i]) begin
          bad = 1;
          $display("FAIL %s @%0t: got %0d expected %0d", fname[i], $time, a[i], e.st[i]);
        end
      end
      if (asleep !== e.asleep) begin
        bad = 1; $display("FAIL asleep @%0t: got %b expected %b", $time, asleep, e.asleep);
      end
      if (dead !== e.dead) begin
        bad = 1; $display("FAIL dead @%0t: got %b expected %b", $time, dead, e.dead);
      end
      if (alert !== e.alert) begin
        bad = 1; $display("FAIL alert @%0t: got %b expected %b", $time, alert, e.alert);
      end
      if (tick !== e.tick) begin
        bad = 1; $display("FAIL tick @%0t: got %b expected %b", $time, tick, e.tick);
      end
      if (bad) n_bad++;
    end
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  task automatic cyc(input bit [7:0] in_v, input bit [7:0] rnd_v);
    inputs = in_v;
    random = rnd_v;
    @(posedge clk);
    model_edge(in_v, rnd_v);
    push_exp();
    #2;
  endtask

  task automatic run_ticks(input int n, input bit [7:0] in_v, input bit [7:0] rnd_v);
    int target;
    int guard;
    target = m_ticks + n;
    guard  = 0;
    while (m_ticks < target && guard < 10000) begin
      cyc(in_v, rnd_v);
      guard++;
    end
  endtask

  task automatic wait_cnt(input int v);
    int guard;
    guard = 0;
    while (m_cnt != v && guard < 2 * TDIV) begin
      cyc(8'h00, 8'h07);
      guard++;
    end
  endtask

  // Reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input int n, input bit [7:0] held);
    @(negedge clk);
    #1;
    inputs = held;
    reset  = 1'b1;
    model_reset();
    #1;
    chk("reset_outputs",
        int'({hunger, happiness, health, hygiene, energy, social, asleep, dead, alert, tick}), 0);
    repeat (n) begin
      @(posedge clk);
      push_exp();
    end
    #2;
    reset = 1'b0;
  endtask

  // ---------------- test sequence ----------------------------------------
  initial begin : stim
    int k;
    reset  = 1'b1;
    inputs = '0;
    random = '0;
    model_reset();

    // decay and saturation on hunger
    do_reset(3, 8'h00);
    run_ticks(20, 8'h00, 8'h00);
    chk("decay_sat_hunger", int'(hunger), 15);
    chk("decay_other_health", int'(health), 0);
    cyc(8'h00, 8'h07);
    chk("decay_alert", int'(alert), 1);

    // care edge detect
    do_reset(2, 8'h00);
    run_ticks(5, 8'h00, 8'h00);
    repeat (10) cyc(8'h01, 8'h07);
    chk("care_held_once", int'(hunger), 4);
    cyc(8'h00, 8'h07); cyc(8'h00, 8'h07);
    cyc(8'h01, 8'h07); cyc(8'h00, 8'h07);
    chk("care_pulse", int'(hunger), 3);
    repeat (5) begin cyc(8'h01, 8'h07); cyc(8'h00, 8'h07); end
    chk("care_floor", int'(hunger), 0);

    // simultaneous decay and care on the same stat
    do_reset(2, 8'h00);
    run_ticks(7, 8'h00, 8'h00);
    wait_cnt(TDIV - 1);
    cyc(8'h01, 8'h00); cyc(8'h00, 8'h00);
    chk("simul_net_zero", int'(hunger), 7);
    wait_cnt(TDIV - 1);
    cyc(8'h01, 8'h06); cyc(8'h00, 8'h06);
    chk("simul_no_sel", int'(hunger), 6);

    // death: medicine between ticks clears the counter, then real death
    do_reset(2, 8'h00);
    run_ticks(15, 8'h00, 8'h02);
    run_ticks(1, 8'h00, 8'h07);
    cyc(8'h04, 8'h07); cyc(8'h00, 8'h07);
    chk("death_medicine", int'(health), 14);
    run_ticks(1, 8'h00, 8'h07);
    chk("death_cleared", int'(dead), 0);
    run_ticks(1, 8'h00, 8'h02);
    run_ticks(2, 8'h00, 8'h07);
    chk("death_dead", int'(dead), 1);
    repeat (40) cyc(8'($urandom), 8'($urandom));
    chk("dead_hold_health", int'(health), 15);
    chk("dead_hold_hunger", int'(hunger), 0);

    // sleep mode (or plain energy care without the sleep build)
    do_reset(2, 8'h00);
    run_ticks(2, 8'h00, 8'h00);
    run_ticks(3, 8'h00, 8'h04);
    cyc(8'h10, 8'h07); cyc(8'h00, 8'h07);
`ifdef PET_STATS_SLEEP_EN
    chk("sleep_enter", int'(asleep), 1);
`endif
    cyc(8'h01, 8'h07); cyc(8'h00, 8'h07);
    run_ticks(3, 8'h00, 8'h07);
`ifdef PET_STATS_SLEEP_EN
    chk("sleep_feed_ignored", int'(hunger), 2);
    chk("sleep_energy_zero", int'(energy), 0);
    chk("sleep_autowake", int'(asleep), 0);
`endif
    run_ticks(3, 8'h00, 8'h04);
    cyc(8'h10, 8'h07); cyc(8'h00, 8'h07);
    run_ticks(1, 8'h00, 8'h07);
    cyc(8'h10, 8'h07); cyc(8'h00, 8'h07);
`ifdef PET_STATS_SLEEP_EN
    chk("wake_press_state", int'(asleep), 0);
    chk("wake_press_energy", int'(energy), 2);
`endif

    // reset mid-operation while asleep, feed held across release
    cyc(8'h10, 8'h07); cyc(8'h00, 8'h07); cyc(8'h00, 8'h07);
    do_reset(2, 8'h01);
    k = 0;
    while (tick !== 1'b1 && k < 8) begin
      cyc(8'h01, 8'h07);
      k++;
    end
    chk("first_tick_cycles", k, TDIV);
    repeat (4) cyc(8'h01, 8'h07);
    chk("held_not_press", int'(hunger), 0);

    // randomized traffic, alternating sparse and dense button activity
    for (int r = 0; r < 6; r++) begin
      do_reset(2, 8'h00);
      for (int c = 0; c < 300; c++) begin
        if (r % 2 == 0)
          cyc(($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
              8'($urandom));
        else
          cyc(8'($urandom) & 8'($urandom) & 8'($urandom), 8'($urandom));
      end
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pet_stats.md
# pet_stats

Parametrised six-channel pet-status engine for the tamagotchi core: it replaces the fixed 4-bit stats block. A free-running tick divider ages one randomly chosen need per tick, edge-detected care buttons relieve needs, and two state machines run on top: a sleep mode for energy recovery and a terminal death state. Outputs drive the display/sprite logic and the sound block.

## Interface
Parameters:
- `STAT_W`, default 4: width of each stat; MAX = 2^STAT_W−1.
- `TICK_DIV`, default 1000: clk cycles per tick, ≥2.
- `DECAY_STEP`, default 1: amount added to the selected need per tick.
- `CARE_STEP`, default 1: amount subtracted per care press or sleep tick.
- `DEATH_TICKS`, default 8: consecutive ticks with health == MAX before death, ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `inputs` in 8: buttons, synchronous and debounced upstream. [0] feed, [1] play, [2] medicine, [3] clean, [4] sleep, [5] socialize, [7:6] unused.
- `random` in 8: LFSR value; only [2:0] used.
- `hunger`, `happiness`, `health`, `hygiene`, `energy`, `social` out STAT_W each: need levels, 0 = satisfied, MAX = critical. Stat index order is 0..5 as listed.
- `asleep` out 1: high in ASLEEP.
- `dead` out 1: high in DEAD.
- `alert` out 1: high when any stat == MAX.
- `tick` out 1: one-cycle pulse per tick period.

## Operation
- Tick divider: counter 0..TICK_DIV−1, wraps to 0. `tick` is registered and high in the cycle after the counter equals TICK_DIV−1. Counter width is clog2(TICK_DIV). Counter runs regardless of button activity.
- Press detect: `press = inputs & ~inputs_q`, where `inputs_q` is the registered previous value. A held button counts once.
- Stat update: each stat is registered. `next = clamp(x + up − down, 0, MAX)`, computed STAT_W+2 bits wide.
  - `up` is DECAY_STEP when a tick selects the stat, else 0.
  - `down` is CARE_STEP on the stat's care press or energy sleep recovery, else 0.
  - When decay and care hit the same stat in the same cycle, both apply as one net step.
- Decay selection on a tick: random[2:0] 0..5 selects that stat index; 6 and 7 select nothing.
- Mode FSM, states AWAKE, ASLEEP, DEAD:
  - AWAKE: presses [0–3], [5] apply care. A press on [4] goes to ASLEEP and does not change energy. Decay applies to any selected stat.
  - ASLEEP: presses [0–3], [5] are ignored. Each tick subtracts CARE_STEP from energy. Decay applies only when hunger is selected. A press on [4] returns to AWAKE.
  - Auto-wake: if a tick brings energy to 0 while ASLEEP, the FSM returns to AWAKE in the same update.
  - DEAD: all stats hold, all presses are ignored, the tick divider keeps running, and `asleep` = 0. Only reset exits DEAD.
- Death counter (clog2(DEATH_TICKS+1) bits), evaluated on each tick using the pre-update health value:
  - health == MAX: counter increments.
  - otherwise: counter clears.
  - When the counter reaches DEATH_TICKS, the FSM enters DEAD. This applies from both AWAKE and ASLEEP.
- `alert` is registered from the post-update stat values.

## Timing
- Reset values: all stats 0, state AWAKE, `asleep` 0, `dead` 0, `alert` 0, `tick` 0, divider 0, death counter 0, `inputs_q` 0.
- Button rising edge sampled at edge N: stat and FSM change are visible after edge N+1. `alert` follows one cycle later.
- Tick: stat, FSM and `dead` changes are visible in the cycle after `tick` is high.
- Reset asserted mid-operation clears all state immediately. A button still held at release is not a press.

## Configuration
- `PET_STATS_SLEEP_EN` defined: the ASLEEP state and auto-wake are built as described.
- `PET_STATS_SLEEP_EN` undefined:
  - No ASLEEP state; `asleep` is tied to 0.
  - Button [4] acts as a plain care press on energy (−CARE_STEP).
  - Decay and death behaviour are unchanged.

## Test plan
All scenarios use STAT_W=4, TICK_DIV=4, DEATH_TICKS=2.
- Decay and saturation: random=0 for 20 ticks → hunger steps 1..15, then stays 15; `alert`=1 from the cycle after the 15th step; other stats stay 0.
- Care edge detect: hunger=5, hold inputs[0] for 10 cycles → hunger=4 after one update only. Pulse again → 3. Presses at hunger=0 leave it at 0.
- Simultaneous events: hunger=7, feed press in the same cycle a tick selects hunger → hunger stays 7. With random=6 at that tick → hunger=6.
- Sleep: energy=3, press [4] → `asleep`=1; feed presses ignored; energy 2,1,0 on three ticks; at 0 `asleep`=0. Pressing [4] while asleep at energy=2 → AWAKE and energy stays 2.
- Death: health=15 and random=7 for two ticks → `dead`=1. Afterwards presses and ticks leave all stats unchanged. A medicine press between the two ticks instead clears the counter and `dead` stays 0.
- Reset mid-tick while in ASLEEP with nonzero stats → all outputs 0 immediately; the first tick arrives 4 cycles after release.
